// File: rtl/floatb_chan_sched.sv
// rtl/floatb_chan_sched.sv - round-robin scheduler sharing one FLOATB between NCH channels
module floatb_chan_sched #(
  parameter int NCH = 4,
  parameter int LAT = 1,
  localparam int CW = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [16*NCH-1:0] sr_in,
  output logic [15:0]       fb_sr,
  input  logic [10:0]       fb_sr0,
  output logic              ack,
  output logic [CW-1:0]     ack_ch,
  output logic [10:0]       sr0_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cur_q, cur_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   fb_sr_d;
  logic [10:0]   sr0_d;
  logic [CW-1:0] ack_ch_d;
  logic          ack_d;

  logic [15:0]   sr_arr [NCH];
  logic [CW-1:0] sel;
  logic          hit;
  logic [CW:0]   idx;

  // Split the flattened SR bus into one word per channel
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      sr_arr[k] = sr_in[16*k +: 16];
    end
  end

  // First asserted request scanning from ptr upward, wrapping at NCH (not at 2**CW)
  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = {1'b0, ptr_q} + (CW+1)'(i);
      if (idx >= (CW+1)'(NCH)) begin
        idx = idx - (CW+1)'(NCH);
      end
      if (!hit && req[idx[CW-1:0]]) begin
        sel = idx[CW-1:0];
        hit = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; everything holds unless a transition updates it
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    fb_sr_d  = fb_sr;
    sr0_d    = sr0_out;
    ack_ch_d = ack_ch;
    ack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          cur_d   = sel;
          fb_sr_d = sr_arr[sel];
          cnt_d   = 4'(LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          sr0_d    = fb_sr0;
          ack_ch_d = cur_q;
          ack_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        ptr_d   = (cur_q == CW'(NCH-1)) ? '0 : cur_q + CW'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      fb_sr   <= '0;
      sr0_out <= '0;
      ack_ch  <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      fb_sr   <= fb_sr_d;
      sr0_out <= sr0_d;
      ack_ch  <= ack_ch_d;
      ack     <= ack_d;
      busy    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_floatb_chan_sched.sv
// tb/tb_floatb_chan_sched.sv - scoreboard bench for floatb_chan_sched
module tb_floatb_chan_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] sr_in;
  logic [15:0] fb_sr;
  logic [10:0] fb_sr0;
  logic        ack;
  logic [1:0]  ack_ch;
  logic [10:0] sr0_out;
  logic        busy;

  logic [2:0]  req3;
  logic [47:0] sr_in3;
  logic [15:0] fb_sr_3;
  logic [10:0] fb_sr0_3;
  logic        ack3;
  logic [1:0]  ack_ch3;
  logic [10:0] sr0_out3;
  logic        busy3;

  floatb_chan_sched #(.NCH(4), .LAT(1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .sr_in(sr_in), .fb_sr(fb_sr),
    .fb_sr0(fb_sr0), .ack(ack), .ack_ch(ack_ch), .sr0_out(sr0_out), .busy(busy)
  );

  floatb_chan_sched #(.NCH(3), .LAT(1)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .sr_in(sr_in3), .fb_sr(fb_sr_3),
    .fb_sr0(fb_sr0_3), .ack(ack3), .ack_ch(ack_ch3), .sr0_out(sr0_out3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // G.726 FLOATB: sign, 4-bit exponent, 6-bit normalised mantissa
  function automatic logic [10:0] floatb_f(input logic [15:0] sr);
    logic [15:0] neg;
    logic [14:0] mag;
    logic [3:0]  e;
    logic [20:0] tmp;
    neg = -sr;
    mag = sr[15] ? neg[14:0] : sr[14:0];
    e = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (mag[i]) e = 4'(i + 1);
    end
    tmp = {mag, 6'b0} >> e;
    return {sr[15], e, (mag == 15'd0) ? 6'd32 : tmp[5:0]};
  endfunction

  // Registered FLOATB instances (LAT=1)
  always @(posedge clk) begin
    fb_sr0   <= floatb_f(fb_sr);
    fb_sr0_3 <= floatb_f(fb_sr_3);
  end

  typedef struct packed {
    logic [3:0]  ch;
    logic [10:0] sr0;
  } exp_t;

  exp_t sb  [$];
  exp_t sb3 [$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int last_ack = -1;
  int n_acks   = 0;
  int n_acks3  = 0;
  int t0       = 0;
  bit drop_on_ack = 1'b1;
  bit gap_chk     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect4(input int ch, input logic [10:0] v);
    sb.push_back({4'(ch), v});
  endtask

  task automatic expect3(input int ch, input logic [10:0] v);
    sb3.push_back({4'(ch), v});
  endtask

  // One cycle: sample outputs at the falling edge and retire scoreboard entries on ack
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    if (ack) begin
      if (sb.size() == 0) begin
        chk("sb4_empty_on_ack", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("ack_ch", 32'(ack_ch), 32'(e.ch));
        chk("sr0_out", 32'(sr0_out), 32'(e.sr0));
      end
      if (gap_chk && last_ack >= 0) chk("ack_gap", 32'(cyc - last_ack), 32'd4);
      last_ack = cyc;
      n_acks++;
      if (drop_on_ack) req[ack_ch] = 1'b0;
    end
    if (ack3) begin
      if (sb3.size() == 0) begin
        chk("sb3_empty_on_ack", 32'(sb3.size()), 32'd1);
      end else begin
        e = sb3.pop_front();
        chk("ack_ch3", 32'(ack_ch3), 32'(e.ch));
        chk("sr0_out3", 32'(sr0_out3), 32'(e.sr0));
      end
      n_acks3++;
      if (drop_on_ack) req3[ack_ch3] = 1'b0;
    end
  endtask

  task automatic wait_acks(input int n4, input int n3, input int budget);
    int tgt4;
    int tgt3;
    tgt4 = n_acks + n4;
    tgt3 = n_acks3 + n3;
    for (int i = 0; i < budget; i++) begin
      if (n_acks >= tgt4 && n_acks3 >= tgt3) break;
      step();
    end
    chk("timeout_acks4", 32'(n_acks), 32'(tgt4));
    chk("timeout_acks3", 32'(n_acks3), 32'(tgt3));
  endtask

  task automatic set_sr(input int k, input logic [15:0] v);
    sr_in[16*k +: 16] = v;
  endtask

  initial begin
    reset = 1'b0; req = '0; sr_in = '0; req3 = '0; sr_in3 = '0;
    step(); step();
    chk("rst_fb_sr", 32'(fb_sr), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_ack_ch", 32'(ack_ch), 32'd0);
    chk("rst_sr0_out", 32'(sr0_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    step();

    // Single request on ch2, latency and busy width
    set_sr(2, 16'h0001); req[2] = 1'b1; expect4(2, 11'h060);
    t0 = cyc; busy_cnt = 0;
    step();
    chk("t1_fb_sr", 32'(fb_sr), 32'h0001);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_acks(1, 0, 20);
    chk("t1_latency", 32'(last_ack - t0), 32'd3);
    step();
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd3);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    step();

    // Zero and negative values
    set_sr(0, 16'h0000); req[0] = 1'b1; expect4(0, 11'h020);
    wait_acks(1, 0, 20);
    set_sr(1, 16'hFFFF); req[1] = 1'b1; expect4(1, 11'h460);
    wait_acks(1, 0, 20);
    step(); step();

    // All channels requesting from reset: strict rotation, 4-cycle spacing
    reset = 1'b0;
    set_sr(0, 16'h1234); set_sr(1, 16'hF000); set_sr(2, 16'h0040); set_sr(3, 16'h7FFF);
    req = 4'hF;
    step(); step();
    reset = 1'b1;
    drop_on_ack = 1'b0; gap_chk = 1'b1; last_ack = -1;
    expect4(0, floatb_f(16'h1234)); expect4(1, floatb_f(16'hF000));
    expect4(2, floatb_f(16'h0040)); expect4(3, floatb_f(16'h7FFF));
    expect4(0, floatb_f(16'h1234));
    wait_acks(5, 0, 60);
    req = '0; gap_chk = 1'b0; drop_on_ack = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Pointer wrap after serving the last channel
    set_sr(3, 16'h0200); req[3] = 1'b1; expect4(3, floatb_f(16'h0200));
    wait_acks(1, 0, 20);
    step();
    set_sr(0, 16'hC000); req = 4'b1001;
    expect4(0, floatb_f(16'hC000)); expect4(3, floatb_f(16'h0200));
    wait_acks(2, 0, 30);
    step();

    // Mid-service disturbance: SR latched at grant, ack survives req drop
    set_sr(1, 16'h0100); req[1] = 1'b1; expect4(1, floatb_f(16'h0100));
    step();
    set_sr(1, 16'hFFFF); req[1] = 1'b0;
    step();
    chk("t5_fb_sr_held", 32'(fb_sr), 32'h0100);
    wait_acks(1, 0, 20);
    for (int i = 0; i < 5; i++) step();

    // Reset during WAIT aborts conversion and clears pointer
    set_sr(2, 16'h0050); req[2] = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("t6_rst_fb_sr", 32'(fb_sr), 32'd0);
    chk("t6_rst_ack", 32'(ack), 32'd0);
    chk("t6_rst_ack_ch", 32'(ack_ch), 32'd0);
    chk("t6_rst_sr0_out", 32'(sr0_out), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    set_sr(0, 16'hFC00); req[0] = 1'b1;
    expect4(0, floatb_f(16'hFC00)); expect4(2, floatb_f(16'h0050));
    t0 = cyc;
    wait_acks(1, 0, 20);
    chk("t6_latency", 32'(last_ack - t0), 32'd3);
    wait_acks(1, 0, 20);
    step();

    // Three-channel instance: wrap from ch2 back to ch0
    sr_in3[32 +: 16] = 16'h0007; req3[2] = 1'b1; expect3(2, floatb_f(16'h0007));
    wait_acks(0, 1, 20);
    step();
    sr_in3[0 +: 16] = 16'h8001; req3 = 3'b101;
    expect3(0, floatb_f(16'h8001)); expect3(2, floatb_f(16'h0007));
    wait_acks(0, 2, 30);

    for (int i = 0; i < 6; i++) step();
    chk("sb_leftover", 32'(sb.size() + sb3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
